// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32x64 register file.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int ZERO_REG = 31;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_if.sv
// Writeback write port plus two decode-stage read ports of the register file.
interface regfile_if;
  import regfile_pkg::*;

  logic      RegWrite;
  reg_addr_t WriteRegister;
  reg_data_t WriteData;
  reg_addr_t ReadRegister1;
  reg_addr_t ReadRegister2;
  reg_data_t ReadData1;
  reg_data_t ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/dec_5to32_en.sv
// Enabled 5-to-32 one-hot decoder built up from 1-to-2 leaves:
// a 2-to-4 stage on in[4:3] gates four 3-to-8 stages on in[2:0].
module dec_1to2 (
  input  logic       en,
  input  logic       in,
  output logic [1:0] out
);
  assign out = {en & in, en & ~in};
endmodule

module dec_2to4 (
  input  logic       en,
  input  logic [1:0] in,
  output logic [3:0] out
);
  logic [1:0] split;

  dec_1to2 u_split (.en(en), .in(in[1]), .out(split));
  dec_1to2 u_lo    (.en(split[0]), .in(in[0]), .out(out[1:0]));
  dec_1to2 u_hi    (.en(split[1]), .in(in[0]), .out(out[3:2]));
endmodule

module dec_3to8 (
  input  logic       en,
  input  logic [2:0] in,
  output logic [7:0] out
);
  logic [1:0] split;

  dec_1to2 u_split (.en(en), .in(in[2]), .out(split));
  dec_2to4 u_lo    (.en(split[0]), .in(in[1:0]), .out(out[3:0]));
  dec_2to4 u_hi    (.en(split[1]), .in(in[1:0]), .out(out[7:4]));
endmodule

module dec_5to32_en (
  input  logic        en,
  input  logic [4:0]  in,
  output logic [31:0] out
);
  logic [3:0] grp;

  dec_2to4 u_top (.en(en), .in(in[4:3]), .out(grp));

  for (genvar g = 0; g < 4; g++) begin : g_oct
    dec_3to8 u_oct (.en(grp[g]), .in(in[2:0]), .out(out[8*g +: 8]));
  end
endmodule

// File: rtl/regfile_32x64.sv
// 32x64 register file: one clocked write port, two combinational read ports,
// register 31 hardwired to zero with no storage behind it.
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave bus
);
  logic [NUM_REGS-1:0] en;
  reg_data_t           rf_q    [ZERO_REG];
  reg_data_t           rf_view [NUM_REGS];
  logic                unused_en_zero;

  dec_5to32_en u_dec (
    .en  (bus.RegWrite),
    .in  (bus.WriteRegister),
    .out (en)
  );

  // Writes aimed at the zero register decode but land nowhere.
  assign unused_en_zero = en[ZERO_REG];

  always_ff @(posedge clk) begin
    for (int i = 0; i < ZERO_REG; i++) begin
      if (reset) begin
        rf_q[i] <= '0;
      end else if (en[i]) begin
        rf_q[i] <= bus.WriteData;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_view[i] = '0;
    end
    for (int i = 0; i < ZERO_REG; i++) begin
      rf_view[i] = rf_q[i];
    end
  end

  // No write-to-read bypass; forwarding is handled upstream in the pipeline.
  assign bus.ReadData1 = rf_view[bus.ReadRegister1];
  assign bus.ReadData2 = rf_view[bus.ReadRegister2];
endmodule
